// File: rtl/ahb_lite_apb_bridge.sv
// ahb_lite_apb_bridge
//   AHB-Lite slave that turns each accepted AHB transfer into a single APB4
//   transfer (SETUP then ACCESS). AHB and APB share HCLK. HREADYOUT, HRESP
//   and HRDATA are registered and feed this slave's slot in the response mux.
//
//   Optional feature macro: APB_PSLVERR_EN
//     defined   : PSLVERR at completion gives a two-cycle AHB ERROR response
//     undefined : PSLVERR is ignored and HRESP stays 0
//
//   Ports
//     HCLK, HRESETn          clock, asynchronous active-low reset
//     HSEL, HADDR, HTRANS,   AHB address phase
//     HWRITE, HSIZE, HREADY
//     HWDATA                 AHB write data (data phase)
//     HREADYOUT, HRESP,      AHB response to the slave mux
//     HRDATA
//     PSEL, PENABLE, PADDR,  APB4 requester side
//     PWRITE, PWDATA, PSTRB
//     PRDATA, PREADY,        APB4 completer response
//     PSLVERR
//
//   state  | meaning
//   IDLE   | no APB transfer; accepts a new AHB transfer
//   SETUP  | PSEL=1 PENABLE=0; HWDATA passed straight to PWDATA
//   ACCESS | PSEL=1 PENABLE=1; waits for PREADY
//   ERR1   | first error cycle: HREADYOUT=0 HRESP=1
//   ERR2   | second error cycle: HREADYOUT=1 HRESP=1; may accept
module ahb_lite_apb_bridge #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t      state;
   logic [31:0] pwdata_q;
   logic        accept;
   logic        err;
   logic [3:0]  strb_nxt;
   logic        unused_inputs;

   assign accept = HSEL & HREADY & HTRANS[1];

`ifdef APB_PSLVERR_EN
   assign err           = PSLVERR;
   assign unused_inputs = ^HADDR[31:ADDR_WIDTH];
`else
   assign err           = 1'b0;
   assign unused_inputs = ^{HADDR[31:ADDR_WIDTH], PSLVERR};
`endif

   always_comb begin
      strb_nxt = 4'h0;
      if (HWRITE) begin
         case (HSIZE)
            3'd0:    strb_nxt = 4'b0001 << HADDR[1:0];
            3'd1:    strb_nxt = 4'b0011 << {HADDR[1], 1'b0};
            default: strb_nxt = 4'hF;
         endcase
      end
   end

   // HWDATA is only valid during the data phase, which coincides with SETUP;
   // it is passed through there and held from the register during ACCESS.
   assign PWDATA = (state == ST_SETUP) ? HWDATA : pwdata_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PSTRB     <= 4'h0;
         pwdata_q  <= 32'h0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= 32'h0;
      end else begin
         case (state)
            ST_IDLE, ST_ERR2: begin
               HRESP <= 1'b0;
               if (accept) begin
                  state     <= ST_SETUP;
                  PSEL      <= 1'b1;
                  PENABLE   <= 1'b0;
                  PADDR     <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
                  PWRITE    <= HWRITE;
                  PSTRB     <= strb_nxt;
                  HREADYOUT <= 1'b0;
               end else begin
                  state     <= ST_IDLE;
                  HREADYOUT <= 1'b1;
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               PENABLE  <= 1'b1;
               pwdata_q <= HWDATA;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (!PWRITE) HRDATA <= PRDATA;
                  if (err) begin
                     state <= ST_ERR1;
                     HRESP <= 1'b1;
                  end else begin
                     state     <= ST_IDLE;
                     HREADYOUT <= 1'b1;
                  end
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_lite_apb_bridge.sv
// tb_ahb_lite_apb_bridge
//   Directed bench for ahb_lite_apb_bridge. HREADY is looped back from
//   HREADYOUT as if this were the only slave on the mux. Works with and
//   without APB_PSLVERR_EN defined.
module tb_ahb_lite_apb_bridge;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        psel;
   logic        penable;
   logic [15:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int vecs = 0;
   int errs = 0;

   always #5 hclk = ~hclk;
   assign hready = hreadyout;

   ahb_lite_apb_bridge #(.ADDR_WIDTH(16)) dut (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .PSEL(psel),
      .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   // Drives one AHB transfer and the APB completer response. Snapshots APB
   // signals in the SETUP cycle, counts HREADYOUT-low cycles and returns at
   // the first negedge where HREADYOUT is high again. b2b=1 presents the
   // address phase immediately (caller sits in a completion cycle).
   task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int nwait, input logic slverr, input bit b2b,
                           output logic s_psel, output logic s_pen, output logic [15:0] s_addr,
                           output logic s_pwrite, output logic [3:0] s_strb,
                           output logic [31:0] s_pwdata, output int low, output logic resp_seen);
      int acc;
      if (!b2b) begin @(posedge hclk); #1; end
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
      prdata = rdata; pslverr = slverr; pready = 1'b0;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
      @(negedge hclk);
      s_psel = psel; s_pen = penable; s_addr = paddr; s_pwrite = pwrite;
      s_strb = pstrb; s_pwdata = pwdata;
      low = (hreadyout == 1'b0) ? 1 : 0;
      resp_seen = hresp;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge hclk); #1;
         if (penable) begin
            pready = (acc >= nwait);
            acc++;
         end
         @(negedge hclk);
         if (hreadyout) break;
         low++;
         resp_seen = resp_seen | hresp;
      end
      pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic test_reset();
      hresetn = 1'b0;
      repeat (2) @(negedge hclk);
      vecs++; if (hreadyout !== 1'b1) begin errs++; $display("FAIL rst_hreadyout: got %b want 1", hreadyout); end
      vecs++; if (hresp !== 1'b0) begin errs++; $display("FAIL rst_hresp: got %b want 0", hresp); end
      vecs++; if (hrdata !== 32'h0) begin errs++; $display("FAIL rst_hrdata: got %h want 0", hrdata); end
      vecs++; if ({psel, penable, pwrite} !== 3'b000) begin errs++; $display("FAIL rst_apb_ctl: got %b want 000", {psel, penable, pwrite}); end
      vecs++; if (paddr !== 16'h0) begin errs++; $display("FAIL rst_paddr: got %h want 0", paddr); end
      vecs++; if (pstrb !== 4'h0) begin errs++; $display("FAIL rst_pstrb: got %h want 0", pstrb); end
      vecs++; if (pwdata !== 32'h0) begin errs++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
      hresetn = 1'b1;
      @(negedge hclk);
   endtask

   task automatic test_word_write();
      logic s_psel, s_pen, s_pwrite, rs;
      logic [15:0] s_addr;
      logic [3:0] s_strb;
      logic [31:0] s_pwdata;
      int low;
      run_xfer(32'h4000_0010, 1'b1, 3'd2, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0,
               s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
      vecs++; if ({s_psel, s_pen} !== 2'b10) begin errs++; $display("FAIL ww_setup_ctl: got %b want 10", {s_psel, s_pen}); end
      vecs++; if (s_addr !== 16'h0010) begin errs++; $display("FAIL ww_paddr: got %h want 0010", s_addr); end
      vecs++; if (s_pwrite !== 1'b1) begin errs++; $display("FAIL ww_pwrite: got %b want 1", s_pwrite); end
      vecs++; if (s_strb !== 4'hF) begin errs++; $display("FAIL ww_pstrb: got %h want f", s_strb); end
      vecs++; if (s_pwdata !== 32'h1234_5678) begin errs++; $display("FAIL ww_pwdata: got %h want 12345678", s_pwdata); end
      vecs++; if (low !== 2) begin errs++; $display("FAIL ww_wait: got %0d want 2", low); end
      vecs++; if ({psel, penable, hresp} !== 3'b000) begin errs++; $display("FAIL ww_done: got %b want 000", {psel, penable, hresp}); end
   endtask

   // Checks ACCESS phase signals and PWDATA stability mid-transfer.
   task automatic test_access_phase();
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b11; haddr = 32'h4000_0008; hwrite = 1'b1; hsize = 3'd2; pready = 1'b0;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hA5A5_0F0F;
      @(posedge hclk); #1;
      hwdata = 32'hDEAD_DEAD;
      @(negedge hclk);
      vecs++; if ({psel, penable, hreadyout} !== 3'b110) begin errs++; $display("FAIL acc_ctl: got %b want 110", {psel, penable, hreadyout}); end
      vecs++; if (pwdata !== 32'hA5A5_0F0F) begin errs++; $display("FAIL acc_pwdata: got %h want a5a50f0f", pwdata); end
      @(posedge hclk); #1;
      pready = 1'b1;
      @(negedge hclk);
      vecs++; if (pwdata !== 32'hA5A5_0F0F) begin errs++; $display("FAIL acc_pwdata_hold: got %h want a5a50f0f", pwdata); end
      @(posedge hclk); #1;
      pready = 1'b0;
      @(negedge hclk);
      vecs++; if ({psel, hreadyout} !== 2'b01) begin errs++; $display("FAIL acc_done: got %b want 01", {psel, hreadyout}); end
   endtask

   task automatic test_read_wait();
      logic s_psel, s_pen, s_pwrite, rs;
      logic [15:0] s_addr;
      logic [3:0] s_strb;
      logic [31:0] s_pwdata;
      int low;
      run_xfer(32'h4000_0024, 1'b0, 3'd2, 32'h0, 32'hCAFE_F00D, 3, 1'b0, 1'b0,
               s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
      vecs++; if (low !== 5) begin errs++; $display("FAIL rd_wait: got %0d want 5", low); end
      vecs++; if (hrdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL rd_hrdata: got %h want cafef00d", hrdata); end
      vecs++; if (s_strb !== 4'h0) begin errs++; $display("FAIL rd_pstrb: got %h want 0", s_strb); end
      vecs++; if ({s_psel, s_pwrite} !== 2'b10) begin errs++; $display("FAIL rd_setup: got %b want 10", {s_psel, s_pwrite}); end
      vecs++; if (s_addr !== 16'h0024) begin errs++; $display("FAIL rd_paddr: got %h want 0024", s_addr); end
   endtask

   task automatic test_strobes();
      logic s_psel, s_pen, s_pwrite, rs;
      logic [15:0] s_addr;
      logic [3:0] s_strb;
      logic [31:0] s_pwdata;
      int low;
      logic [31:0] addrs [4] = '{32'h4000_0012, 32'h4000_0016, 32'h4000_0033, 32'h4000_0041};
      logic [2:0]  sizes [4] = '{3'd0, 3'd1, 3'd0, 3'd3};
      logic [3:0]  estrb [4] = '{4'b0100, 4'b1100, 4'b1000, 4'b1111};
      logic [15:0] eaddr [4] = '{16'h0010, 16'h0014, 16'h0030, 16'h0040};
      for (int i = 0; i < 4; i++) begin
         run_xfer(addrs[i], 1'b1, sizes[i], 32'h0BAD_0000 + 32'(i), 32'h0, 0, 1'b0, 1'b0,
                  s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
         vecs++; if (s_strb !== estrb[i]) begin errs++; $display("FAIL strb[%0d]: got %b want %b", i, s_strb, estrb[i]); end
         vecs++; if (s_addr !== eaddr[i]) begin errs++; $display("FAIL strb_paddr[%0d]: got %h want %h", i, s_addr, eaddr[i]); end
      end
      vecs++; if (hrdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL hrdata_hold: got %h want cafef00d", hrdata); end
   endtask

   task automatic test_pslverr();
      logic s_psel, s_pen, s_pwrite, rs;
      logic [15:0] s_addr;
      logic [3:0] s_strb;
      logic [31:0] s_pwdata;
      int low;
      run_xfer(32'h4000_0050, 1'b1, 3'd2, 32'h1111_2222, 32'h0, 0, 1'b1, 1'b0,
               s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
`ifdef APB_PSLVERR_EN
      vecs++; if (low !== 3) begin errs++; $display("FAIL err_low: got %0d want 3", low); end
      vecs++; if (rs !== 1'b1) begin errs++; $display("FAIL err1_hresp: got %b want 1", rs); end
      vecs++; if (hresp !== 1'b1) begin errs++; $display("FAIL err2_hresp: got %b want 1", hresp); end
      @(negedge hclk);
      vecs++; if ({hreadyout, hresp} !== 2'b10) begin errs++; $display("FAIL err_after: got %b want 10", {hreadyout, hresp}); end
`else
      vecs++; if (low !== 2) begin errs++; $display("FAIL noerr_low: got %0d want 2", low); end
      vecs++; if ({rs, hresp} !== 2'b00) begin errs++; $display("FAIL noerr_hresp: got %b want 00", {rs, hresp}); end
`endif
   endtask

   task automatic test_back_to_back();
      logic s_psel, s_pen, s_pwrite, rs;
      logic [15:0] s_addr;
      logic [3:0] s_strb;
      logic [31:0] s_pwdata;
      int low;
      run_xfer(32'h4000_0060, 1'b1, 3'd2, 32'h7777_8888, 32'h0, 0, 1'b0, 1'b0,
               s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
      run_xfer(32'h4000_0064, 1'b0, 3'd2, 32'h0, 32'h5555_AAAA, 1, 1'b0, 1'b1,
               s_psel, s_pen, s_addr, s_pwrite, s_strb, s_pwdata, low, rs);
      vecs++; if ({s_psel, s_pen, s_pwrite} !== 3'b100) begin errs++; $display("FAIL b2b_setup: got %b want 100", {s_psel, s_pen, s_pwrite}); end
      vecs++; if (s_addr !== 16'h0064) begin errs++; $display("FAIL b2b_paddr: got %h want 0064", s_addr); end
      vecs++; if (low !== 3) begin errs++; $display("FAIL b2b_wait: got %0d want 3", low); end
      vecs++; if (hrdata !== 32'h5555_AAAA) begin errs++; $display("FAIL b2b_hrdata: got %h want 5555aaaa", hrdata); end
   endtask

   task automatic test_no_transfer();
      int seen;
      seen = 0;
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b01; haddr = 32'h4000_0070; hwrite = 1'b1;
      repeat (3) begin @(negedge hclk); if (psel || !hreadyout || hresp) seen++; end
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b10;
      repeat (3) begin @(negedge hclk); if (psel || !hreadyout || hresp) seen++; end
      @(posedge hclk); #1;
      htrans = 2'b00;
      vecs++; if (seen !== 0) begin errs++; $display("FAIL no_xfer: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0080; hwrite = 1'b0; pready = 1'b0;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge hclk);
      @(negedge hclk);
      vecs++; if ({psel, penable, hreadyout} !== 3'b110) begin errs++; $display("FAIL mid_access: got %b want 110", {psel, penable, hreadyout}); end
      #2 hresetn = 1'b0;
      #1;
      vecs++; if ({hreadyout, hresp, psel, penable} !== 4'b1000) begin errs++; $display("FAIL mid_reset: got %b want 1000", {hreadyout, hresp, psel, penable}); end
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
   endtask

   initial begin
      hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd2; hwdata = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      test_reset();
      test_word_write();
      test_access_phase();
      test_read_wait();
      test_strobes();
      test_pslverr();
      test_back_to_back();
      test_no_transfer();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
